// File: rtl/fx_ramp_accum_pkg.sv
// Shared definitions for the fixed-point ramp accumulator.
// Holds the default format constants (Q fractional bits, N word width,
// CW step-counter width) and the control FSM state encoding.
package fx_ramp_accum_pkg;

    localparam int unsigned FX_Q_DEF  = 15;
    localparam int unsigned FX_N_DEF  = 32;
    localparam int unsigned FX_CW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fx_state_e;

endpackage

// File: rtl/fx_ramp_accum_if.sv
// Control/data bundle of the ramp accumulator.
//   master : drives start, abort, init, incr, steps, tick;
//            observes busy, acc, acc_valid, done, sat
//   slave  : the accumulator itself (mirror image of master)
interface fx_ramp_accum_if
    import fx_ramp_accum_pkg::*;
#(
    parameter int unsigned N  = FX_N_DEF,
    parameter int unsigned CW = FX_CW_DEF
) ();

    logic          start;
    logic          abort;
    logic [N-1:0]  init;
    logic [N-1:0]  incr;
    logic [CW-1:0] steps;
    logic          tick;
    logic          busy;
    logic [N-1:0]  acc;
    logic          acc_valid;
    logic          done;
    logic          sat;

    modport master (
        output start, abort, init, incr, steps, tick,
        input  busy, acc, acc_valid, done, sat
    );

    modport slave (
        input  start, abort, init, incr, steps, tick,
        output busy, acc, acc_valid, done, sat
    );

endinterface

// File: rtl/fx_sat_add.sv
// Saturating sign-magnitude adder (combinational).
//   a, b : N-bit operands, MSB = sign, N-2:0 = magnitude
//   c    : sum; magnitude clamps to all-ones on overflow, sign kept;
//          a zero magnitude is always returned with sign 0
//   ovf  : high when the magnitude was clamped
module fx_sat_add #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] c,
    output logic         ovf
);

    localparam int unsigned M = N - 1;

    logic         sa;
    logic         sb;
    logic [M-1:0] ma;
    logic [M-1:0] mb;
    logic [M:0]   sum;
    logic [M-1:0] diff_ab;
    logic [M-1:0] diff_ba;
    logic [M-1:0] mag;
    logic         sgn;

    assign sa      = a[N-1];
    assign sb      = b[N-1];
    assign ma      = a[M-1:0];
    assign mb      = b[M-1:0];
    assign sum     = {1'b0, ma} + {1'b0, mb};
    assign diff_ab = ma - mb;
    assign diff_ba = mb - ma;

    always_comb begin
        ovf = 1'b0;
        sgn = sa;
        mag = '0;
        if (sa == sb) begin
            if (sum[M]) begin
                mag = '1;
                ovf = 1'b1;
            end else begin
                mag = sum[M-1:0];
            end
        end else if (ma > mb) begin
            mag = diff_ab;
        end else begin
            sgn = sb;
            mag = diff_ba;
        end
        // Never emit negative zero (covers exact cancellation and -0 operands).
        if (mag == '0) begin
            sgn = 1'b0;
        end
        c = {sgn, mag};
    end

endmodule

// File: rtl/fx_ramp_accum.sv
// Fixed-point ramp accumulator.
// On an accepted start the accumulator loads init and then adds incr once
// per tick for `steps` ticks, using saturating sign-magnitude arithmetic.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of fx_ramp_accum_if
//                start/abort/init/incr/steps/tick in,
//                busy/acc/acc_valid/done/sat out (all registered)
module fx_ramp_accum
    import fx_ramp_accum_pkg::*;
#(
    parameter int unsigned Q  = FX_Q_DEF,
    parameter int unsigned N  = FX_N_DEF,
    parameter int unsigned CW = FX_CW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    fx_ramp_accum_if.slave     bus
);

    // Q only describes the binary point; the datapath is format agnostic.
    if (Q >= N - 1) begin : g_bad_q
        $error("fx_ramp_accum: Q must be smaller than N-1");
    end

    fx_state_e     state_q;
    logic [N-1:0]  acc_q;
    logic [N-1:0]  incr_q;
    logic [CW-1:0] rem_q;
    logic          busy_q;
    logic          acc_valid_q;
    logic          done_q;
    logic          sat_q;

    logic [N-1:0]  init_norm_d;
    logic [N-1:0]  acc_d;
    logic          ovf_d;
    logic [CW-1:0] rem_d;
    logic          last_tick_d;

    fx_sat_add #(.N(N)) u_add (
        .a   (acc_q),
        .b   (incr_q),
        .c   (acc_d),
        .ovf (ovf_d)
    );

    // A loaded -0 is folded to +0 so acc never presents negative zero.
    assign init_norm_d = (bus.init[N-2:0] == '0) ? '0 : bus.init;
    assign rem_d       = rem_q - CW'(1);
    assign last_tick_d = (rem_q == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            incr_q      <= '0;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            acc_valid_q <= 1'b0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            acc_valid_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // start wins over a simultaneous abort here.
                    if (bus.start) begin
                        acc_q  <= init_norm_d;
                        incr_q <= bus.incr;
                        rem_q  <= bus.steps;
                        sat_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (bus.steps != '0) begin
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (bus.tick) begin
                        acc_q       <= acc_d;
                        rem_q       <= rem_d;
                        acc_valid_q <= 1'b1;
                        if (ovf_d) begin
                            sat_q <= 1'b1;
                        end
                        if (last_tick_d) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.acc       = acc_q;
    assign bus.acc_valid = acc_valid_q;
    assign bus.done      = done_q;
    assign bus.sat       = sat_q;

endmodule
